sym_sched: RTL and testbench

SYM_SCHED -- requirements
Module: sym_sched

---
 rtl/sched_pkg.sv | 17 +
 rtl/rr_pick3.sv | 34 +++
 rtl/sym_sched.sv | 139 +++++++++++++
 tb/tb_sym_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared constants and state encoding for the symbol scheduler.
// Imported by the arbiter and the scheduler top.
package sched_pkg;

  localparam int NREQ      = 3;
  localparam int MAX_BURST = 4;
  localparam int SYM_W     = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    XFER = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4
  } state_t;

endpackage

// File: rtl/rr_pick3.sv
// Three-way round-robin picker: first set req bit from ptr upward.
// Purely combinational; caller registers the winner and next ptr.
module rr_pick3
  import sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt,
  output logic       any
);

  always_comb begin
    gnt = 2'd0;
    any = |req;
    case (ptr)
      2'd1: begin
        if (req[1])      gnt = 2'd1;
        else if (req[2]) gnt = 2'd2;
        else if (req[0]) gnt = 2'd0;
      end
      2'd2: begin
        if (req[2])      gnt = 2'd2;
        else if (req[0]) gnt = 2'd0;
        else if (req[1]) gnt = 2'd1;
      end
      default: begin
        if (req[0])      gnt = 2'd0;
        else if (req[1]) gnt = 2'd1;
        else if (req[2]) gnt = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/sym_sched.sv
// Packet scheduler: arbitrates three symbol sources into one shared
// Moore FSM and captures its verdict once per packet.
module sym_sched
  import sched_pkg::*;
#(
  parameter int NREQ      = sched_pkg::NREQ,
  parameter int MAX_BURST = sched_pkg::MAX_BURST
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      sym0,
  input  logic [1:0]      sym1,
  input  logic [1:0]      sym2,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] ack,
  output logic [1:0]      sym_out,
  output logic            sym_vld,
  output logic            fsm_clr,
  input  logic [2:0]      fsm_out,
  output logic [2:0]      result,
  output logic [1:0]      result_id,
  output logic            result_vld,
  output logic            trunc
);

  state_t state, nxt;

  logic [1:0] ptr;
  logic [1:0] gnt;
  logic [1:0] pick;
  logic       any;
  logic [2:0] cnt;

  logic [SYM_W-1:0] sym_gnt;
  logic             req_g;
  logic             last_g;
  logic             take;
  logic             burst_end;
  logic             done;

  rr_pick3 u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick),
    .any (any)
  );

  always_comb begin
    sym_gnt = sym0;
    req_g   = req[0];
    last_g  = last[0];
    case (gnt)
      2'd1: begin
        sym_gnt = sym1;
        req_g   = req[1];
        last_g  = last[1];
      end
      2'd2: begin
        sym_gnt = sym2;
        req_g   = req[2];
        last_g  = last[2];
      end
      default: ;
    endcase
  end

  // clr gates the consume strobe so nothing is acked while in reset
  assign take      = (state == XFER) && clr && req_g;
  assign burst_end = (cnt + 3'd1) == 3'(MAX_BURST);
  assign done      = take && (last_g || burst_end);

  always_comb begin
    ack = '0;
    if (take) ack[gnt] = 1'b1;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (any) nxt = PREP;
      PREP:    nxt = XFER;
      XFER:    if (done) nxt = WAIT;
      WAIT:    nxt = CAPT;
      CAPT:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      ptr        <= 2'd0;
      gnt        <= 2'd0;
      cnt        <= 3'd0;
      sym_out    <= '0;
      sym_vld    <= 1'b0;
      fsm_clr    <= 1'b0;
      result     <= 3'd0;
      result_id  <= 2'd0;
      result_vld <= 1'b0;
      trunc      <= 1'b0;
    end else begin
      fsm_clr    <= 1'b0;
      sym_vld    <= 1'b0;
      result_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt     <= pick;
            ptr     <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            fsm_clr <= 1'b1;
          end
        end
        XFER: begin
          sym_vld <= take;
          if (take) begin
            sym_out <= sym_gnt;
            cnt     <= cnt + 3'd1;
          end
          // last wins over a simultaneous burst limit
          if (done) trunc <= !last_g;
        end
        CAPT: begin
          result     <= fsm_out;
          result_id  <= gnt;
          result_vld <= 1'b1;
          cnt        <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sym_sched.sv
// Scoreboard bench for sym_sched with a summing model of the shared FSM.
module tb_sym_sched;
  import sched_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] req;
  logic [2:0] last;
  logic [1:0] sym0, sym1, sym2;
  logic [2:0] ack;
  logic [1:0] sym_out;
  logic       sym_vld;
  logic       fsm_clr;
  logic [2:0] fsm_out;
  logic [2:0] result;
  logic [1:0] result_id;
  logic       result_vld;
  logic       trunc;

  always #5 clk = ~clk;

  sym_sched dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .sym0       (sym0),
    .sym1       (sym1),
    .sym2       (sym2),
    .last       (last),
    .ack        (ack),
    .sym_out    (sym_out),
    .sym_vld    (sym_vld),
    .fsm_clr    (fsm_clr),
    .fsm_out    (fsm_out),
    .result     (result),
    .result_id  (result_id),
    .result_vld (result_vld),
    .trunc      (trunc)
  );

  // shared FSM stand-in: Moore output = sum of symbols mod 8
  logic [2:0] acc = 3'd0;
  always @(posedge clk) begin
    if (fsm_clr)      acc <= 3'd0;
    else if (sym_vld) acc <= acc + {1'b0, sym_out};
  end
  assign fsm_out = acc;

  typedef struct packed {
    logic [1:0] id;
    logic [2:0] res;
    logic       tr;
  } res_t;

  logic [2:0] q0[$], q1[$], q2[$];
  logic [1:0] exp_sym[$];
  res_t       exp_res[$];
  logic [2:0] stall = 3'b000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ack_cyc = 0;
  int nclr  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic drive();
    req[0] = (q0.size() > 0) && !stall[0];
    req[1] = (q1.size() > 0) && !stall[1];
    req[2] = (q2.size() > 0) && !stall[2];
    sym0 = (q0.size() > 0) ? q0[0][1:0] : 2'd0;
    sym1 = (q1.size() > 0) ? q1[0][1:0] : 2'd0;
    sym2 = (q2.size() > 0) ? q2[0][1:0] : 2'd0;
    last[0] = (q0.size() > 0) ? q0[0][2] : 1'b0;
    last[1] = (q1.size() > 0) ? q1[0][2] : 1'b0;
    last[2] = (q2.size() > 0) ? q2[0][2] : 1'b0;
  endtask

  task automatic add(input int r, input logic [1:0] s, input logic l);
    case (r)
      0:       q0.push_back({l, s});
      1:       q1.push_back({l, s});
      default: q2.push_back({l, s});
    endcase
  endtask

  task automatic want(input logic [1:0] id, input logic [2:0] res,
                      input logic tr);
    res_t e;
    e.id  = id;
    e.res = res;
    e.tr  = tr;
    exp_res.push_back(e);
  endtask

  // requester model: pop a symbol after each acked cycle
  initial begin
    logic [2:0] a;
    forever begin
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      if (a[0] === 1'b1) void'(q0.pop_front());
      if (a[1] === 1'b1) void'(q1.pop_front());
      if (a[2] === 1'b1) void'(q2.pop_front());
      drive();
    end
  end

  // monitor: compares every presented symbol and verdict
  initial begin
    logic [1:0] es;
    res_t       er;
    forever begin
      @(negedge clk);
      if (fsm_clr === 1'b1) nclr++;
      if (clr === 1'b1 && ack !== 3'b000) begin
        chk("ack_onehot", {30'd0, $onehot(ack), ((ack & ~req) == 3'b000)},
            32'd3);
        ack_cyc = cyc;
      end
      if (sym_vld === 1'b1) begin
        if (exp_sym.size() == 0) begin
          chk("sym_extra", {30'd0, sym_out}, 32'hff);
        end else begin
          es = exp_sym.pop_front();
          chk("sym_out", {30'd0, sym_out}, {30'd0, es});
        end
      end
      if (result_vld === 1'b1) begin
        if (exp_res.size() == 0) begin
          chk("res_extra", {26'd0, result_id, result, trunc}, 32'hff);
        end else begin
          er = exp_res.pop_front();
          chk("verdict", {26'd0, result_id, result, trunc}, {26'd0, er});
        end
        chk("latency", cyc - ack_cyc, 32'd3);
      end
    end
  end

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() + exp_sym.size() +
            exp_res.size()) != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("drain", {31'd0, n >= maxc}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int r, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[r] !== 1'b1 && n < maxc);
    chk("ack_seen", {31'd0, ack[r]}, 32'd1);
  endtask

  initial begin
    int n0;
    clr = 1'b0;
    drive();
    add(0, 2'd1, 1'b1); add(0, 2'd2, 1'b1);
    add(1, 2'd2, 1'b1); add(1, 2'd3, 1'b1);
    add(2, 2'd3, 1'b1); add(2, 2'd1, 1'b1);
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", {29'd0, ack}, 32'd0);
      chk("rst_sym_vld", {31'd0, sym_vld}, 32'd0);
      chk("rst_res_vld", {31'd0, result_vld}, 32'd0);
    end
    // rotation 0,1,2,0,1,2 with all three requesting
    exp_sym.push_back(2'd1); exp_sym.push_back(2'd2);
    exp_sym.push_back(2'd3); exp_sym.push_back(2'd2);
    exp_sym.push_back(2'd3); exp_sym.push_back(2'd1);
    want(2'd0, 3'd1, 1'b0); want(2'd1, 3'd2, 1'b0);
    want(2'd2, 3'd3, 1'b0); want(2'd0, 3'd2, 1'b0);
    want(2'd1, 3'd3, 1'b0); want(2'd2, 3'd1, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    wait_drain(300);

    // three-symbol packet from requester 1
    add(1, 2'd1, 1'b0); add(1, 2'd2, 1'b0); add(1, 2'd3, 1'b1);
    exp_sym.push_back(2'd1); exp_sym.push_back(2'd2);
    exp_sym.push_back(2'd3);
    want(2'd1, 3'd6, 1'b0);
    drive();
    wait_drain(100);

    // six symbols: truncated after four, remainder is a new packet
    add(2, 2'd1, 1'b0); add(2, 2'd2, 1'b0); add(2, 2'd3, 1'b0);
    add(2, 2'd1, 1'b0); add(2, 2'd2, 1'b0); add(2, 2'd3, 1'b1);
    exp_sym.push_back(2'd1); exp_sym.push_back(2'd2);
    exp_sym.push_back(2'd3); exp_sym.push_back(2'd1);
    exp_sym.push_back(2'd2); exp_sym.push_back(2'd3);
    want(2'd2, 3'd7, 1'b1);
    want(2'd2, 3'd5, 1'b0);
    drive();
    wait_drain(150);

    // two-cycle stall mid-packet
    add(0, 2'd3, 1'b0); add(0, 2'd1, 1'b0); add(0, 2'd2, 1'b1);
    exp_sym.push_back(2'd3); exp_sym.push_back(2'd1);
    exp_sym.push_back(2'd2);
    want(2'd0, 3'd6, 1'b0);
    drive();
    wait_ack(0, 20);
    @(posedge clk);
    #1;
    stall = 3'b001;
    drive();
    @(negedge clk);
    chk("stall1_ack", {29'd0, ack}, 32'd0);
    chk("stall1_sym", {30'd0, sym_out}, 32'd3);
    @(negedge clk);
    chk("stall2_ack", {29'd0, ack}, 32'd0);
    chk("stall2_vld", {31'd0, sym_vld}, 32'd0);
    chk("stall2_sym", {30'd0, sym_out}, 32'd3);
    @(posedge clk);
    #1;
    stall = 3'b000;
    drive();
    @(negedge clk);
    chk("resume_vld", {31'd0, sym_vld}, 32'd0);
    chk("resume_sym", {30'd0, sym_out}, 32'd3);
    wait_drain(100);

    // reset during WAIT abandons the packet
    n0 = nclr;
    add(1, 2'd2, 1'b1);
    exp_sym.push_back(2'd2);
    drive();
    wait_ack(1, 20);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_res_vld", {31'd0, result_vld}, 32'd0);
    end
    @(posedge clk);
    #1;
    add(2, 2'd3, 1'b1);
    exp_sym.push_back(2'd3);
    want(2'd2, 3'd3, 1'b0);
    drive();
    wait_drain(100);
    chk("abort_clr_pulses", nclr - n0, 32'd2);
    chk("fsm_clr_total", nclr, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
